xctcmsg_tag_mailbox: RTL and testbench

Parametrised tag/source-matching receive mailbox for the xctcmsg unit. It buffers incoming bus messages and serves receive requests that filter by source and/or tag, with wildcards. It returns the oldest matching message in consume or peek mode. It sits between the loopback interceptor (receive side) and the writeback arbiter, replacing the fixed FIFO-order mailbox.

---
 rtl/xctcmsg_tag_mailbox.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_xctcmsg_tag_mailbox.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xctcmsg_tag_mailbox.sv
// xctcmsg_tag_mailbox
// Receive mailbox that buffers incoming bus messages and serves receive
// requests filtered by source and/or tag (each with a wildcard). The oldest
// matching message is returned, either consumed (entry freed) or peeked
// (entry kept). Message age is tracked with an age matrix:
// age_r[i][j] = 1 means entry i is older than entry j.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drops the outstanding request (WAIT/RESP -> IDLE)
//   in_*                incoming message handshake and fields
//   req_*               receive request: filters, peek mode, destination rd
//   rsp_*               response handshake, matched entry fields, echoed rd
//   occupancy_o         number of valid entries
module xctcmsg_tag_mailbox #(
    parameter int SIZE   = 4,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 32,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_W-1:0]          in_src_i,
    input  logic [TAG_W-1:0]           in_tag_i,
    input  logic [DATA_W-1:0]          in_msg_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [ADDR_W-1:0]          req_src_i,
    input  logic                       req_src_any_i,
    input  logic [TAG_W-1:0]           req_tag_i,
    input  logic                       req_tag_any_i,
    input  logic                       req_peek_i,
    input  logic [4:0]                 req_rd_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [ADDR_W-1:0]          rsp_src_o,
    output logic [TAG_W-1:0]           rsp_tag_o,
    output logic [DATA_W-1:0]          rsp_msg_o,
    output logic [4:0]                 rsp_rd_o,
    output logic [$clog2(SIZE+1)-1:0]  occupancy_o
);

    localparam int IDX_W = $clog2(SIZE);
    localparam int OCC_W = $clog2(SIZE+1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_r, state_next_s;

    logic [SIZE-1:0]      valid_r;
    logic [ADDR_W-1:0]    src_r [SIZE];
    logic [TAG_W-1:0]     tag_r [SIZE];
    logic [DATA_W-1:0]    msg_r [SIZE];
    logic [SIZE-1:0]      age_r [SIZE];
    logic [OCC_W-1:0]     occ_r, occ_next_s;

    logic [ADDR_W-1:0]    q_src_r;
    logic                 q_src_any_r;
    logic [TAG_W-1:0]     q_tag_r;
    logic                 q_tag_any_r;
    logic                 q_peek_r;
    logic [4:0]           q_rd_r;
    logic [IDX_W-1:0]     lock_r;

    logic                 in_ready_r, req_ready_r, rsp_valid_r;
    logic [ADDR_W-1:0]    rsp_src_r;
    logic [TAG_W-1:0]     rsp_tag_r;
    logic [DATA_W-1:0]    rsp_msg_r;
    logic [4:0]           rsp_rd_r;

    logic                 ins_en_s, free_en_s, capture_s, lock_en_s;
    logic [IDX_W-1:0]     ins_idx_s, hit_idx_s;
    logic                 ins_found_s, hit_s;
    logic [SIZE-1:0]      match_s, older_s;

    assign ins_en_s = in_valid_i && in_ready_r;

    // Lowest-index free slot; an entry being freed this cycle is still valid_r,
    // so it is never chosen (no same-cycle reuse).
    always_comb begin
        ins_idx_s   = {IDX_W{1'b0}};
        ins_found_s = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (!valid_r[i] && !ins_found_s) begin
                ins_idx_s   = IDX_W'(i);
                ins_found_s = 1'b1;
            end else begin
                ins_found_s = ins_found_s;
            end
        end
    end

    // Filter every entry against the registered request.
    always_comb begin
        match_s = {SIZE{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            match_s[i] = valid_r[i]
                       && (q_src_any_r || (src_r[i] == q_src_r))
                       && (q_tag_any_r || (tag_r[i] == q_tag_r));
        end
    end

    // older_s[i]: some other matching entry is older than entry i.
    always_comb begin
        older_s = {SIZE{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                older_s[i] = older_s[i] | (match_s[j] & age_r[j][i]);
            end
        end
    end

    // Oldest match: the matching entry with no older matching entry.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            if (match_s[i] && !older_s[i] && !hit_s) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Next-state logic and control strobes; flush always wins over progress.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        lock_en_s    = 1'b0;
        free_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i && !flush) begin
                    state_next_s = ST_WAIT;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (hit_s) begin
                    state_next_s = ST_RESP;
                    lock_en_s    = 1'b1;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (rsp_ready_i) begin
                    state_next_s = ST_IDLE;
                    free_en_s    = !q_peek_r;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy after this cycle's insert and/or free.
    always_comb begin
        case ({ins_en_s, free_en_s})
            2'b10:   occ_next_s = occ_r + OCC_W'(1);
            2'b01:   occ_next_s = occ_r - OCC_W'(1);
            default: occ_next_s = occ_r;
        endcase
    end

    // FSM state, occupancy and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            occ_r       <= {OCC_W{1'b0}};
            in_ready_r  <= 1'b1;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            occ_r       <= occ_next_s;
            in_ready_r  <= (occ_next_s < OCC_W'(SIZE));
            req_ready_r <= (state_next_s == ST_IDLE);
            rsp_valid_r <= (state_next_s == ST_RESP);
        end
    end

    // Request capture and response data; response fields stay stable in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_src_r     <= {ADDR_W{1'b0}};
            q_src_any_r <= 1'b0;
            q_tag_r     <= {TAG_W{1'b0}};
            q_tag_any_r <= 1'b0;
            q_peek_r    <= 1'b0;
            q_rd_r      <= 5'd0;
            lock_r      <= {IDX_W{1'b0}};
            rsp_src_r   <= {ADDR_W{1'b0}};
            rsp_tag_r   <= {TAG_W{1'b0}};
            rsp_msg_r   <= {DATA_W{1'b0}};
            rsp_rd_r    <= 5'd0;
        end else begin
            if (capture_s) begin
                q_src_r     <= req_src_i;
                q_src_any_r <= req_src_any_i;
                q_tag_r     <= req_tag_i;
                q_tag_any_r <= req_tag_any_i;
                q_peek_r    <= req_peek_i;
                q_rd_r      <= req_rd_i;
            end
            if (lock_en_s) begin
                lock_r    <= hit_idx_s;
                rsp_src_r <= src_r[hit_idx_s];
                rsp_tag_r <= tag_r[hit_idx_s];
                rsp_msg_r <= msg_r[hit_idx_s];
                rsp_rd_r  <= q_rd_r;
            end
        end
    end

    // Entry storage: write on insert, invalidate on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {SIZE{1'b0}};
            for (int i = 0; i < SIZE; i++) begin
                src_r[i] <= {ADDR_W{1'b0}};
                tag_r[i] <= {TAG_W{1'b0}};
                msg_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (free_en_s) begin
                valid_r[lock_r] <= 1'b0;
            end
            if (ins_en_s) begin
                valid_r[ins_idx_s] <= 1'b1;
                src_r[ins_idx_s]   <= in_src_i;
                tag_r[ins_idx_s]   <= in_tag_i;
                msg_r[ins_idx_s]   <= in_msg_i;
            end
        end
    end

    // Age matrix: a new entry is younger than every valid entry; a freed
    // entry's row and column are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SIZE; k++) begin
                age_r[k] <= {SIZE{1'b0}};
            end
        end else begin
            for (int k = 0; k < SIZE; k++) begin
                for (int j = 0; j < SIZE; j++) begin
                    if (free_en_s && ((IDX_W'(k) == lock_r) || (IDX_W'(j) == lock_r))) begin
                        age_r[k][j] <= 1'b0;
                    end else if (ins_en_s && (IDX_W'(j) == ins_idx_s)) begin
                        age_r[k][j] <= valid_r[k];
                    end else if (ins_en_s && (IDX_W'(k) == ins_idx_s)) begin
                        age_r[k][j] <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready_o  = in_ready_r;
    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_src_o   = rsp_src_r;
    assign rsp_tag_o   = rsp_tag_r;
    assign rsp_msg_o   = rsp_msg_r;
    assign rsp_rd_o    = rsp_rd_r;
    assign occupancy_o = occ_r;

endmodule

// File: tb/tb_xctcmsg_tag_mailbox.sv
// Self-checking bench for xctcmsg_tag_mailbox. A reference model keeps the
// stored messages as an arrival-ordered queue; the oldest match is the first
// matching queue element.
module tb_xctcmsg_tag_mailbox;

    localparam int SIZE   = 4;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 32;
    localparam int DATA_W = 64;

    logic              clk, rst_n, flush;
    logic              in_valid_i, in_ready_o;
    logic [ADDR_W-1:0] in_src_i;
    logic [TAG_W-1:0]  in_tag_i;
    logic [DATA_W-1:0] in_msg_i;
    logic              req_valid_i, req_ready_o;
    logic [ADDR_W-1:0] req_src_i;
    logic              req_src_any_i;
    logic [TAG_W-1:0]  req_tag_i;
    logic              req_tag_any_i, req_peek_i;
    logic [4:0]        req_rd_i;
    logic              rsp_valid_o, rsp_ready_i;
    logic [ADDR_W-1:0] rsp_src_o;
    logic [TAG_W-1:0]  rsp_tag_o;
    logic [DATA_W-1:0] rsp_msg_o;
    logic [4:0]        rsp_rd_o;
    logic [$clog2(SIZE+1)-1:0] occupancy_o;

    xctcmsg_tag_mailbox #(.SIZE(SIZE), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_src_i(in_src_i), .in_tag_i(in_tag_i), .in_msg_i(in_msg_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_src_i(req_src_i), .req_src_any_i(req_src_any_i),
        .req_tag_i(req_tag_i), .req_tag_any_i(req_tag_any_i),
        .req_peek_i(req_peek_i), .req_rd_i(req_rd_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_src_o(rsp_src_o), .rsp_tag_o(rsp_tag_o), .rsp_msg_o(rsp_msg_o),
        .rsp_rd_o(rsp_rd_o), .occupancy_o(occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] tag;
        logic [63:0] msg;
    } msg_t;

    // Reference model: stored messages oldest-first, plus the pending request.
    msg_t        mq[$];
    int          m_phase;      // 0 idle, 1 waiting for a match, 2 responding
    int          m_lock;
    logic [31:0] m_src, m_tag;
    logic        m_src_any, m_tag_any, m_peek;
    logic [4:0]  m_rd;
    bit          m_ins_fired;

    function automatic bit entry_match(input msg_t e);
        return (m_src_any || e.src == m_src) && (m_tag_any || e.tag == m_tag);
    endfunction

    // One clock cycle: compare outputs with the model, then advance the model.
    task automatic tick();
        msg_t e;
        bit   ins;
        int   found;
        @(negedge clk);
        check_eq("occupancy", 64'(occupancy_o), 64'(mq.size()));
        check_eq("in_ready", 64'(in_ready_o), 64'(mq.size() < SIZE));
        check_eq("req_ready", 64'(req_ready_o), 64'(m_phase == 0));
        check_eq("rsp_valid", 64'(rsp_valid_o), 64'(m_phase == 2));
        if (m_phase == 2) begin
            check_eq("rsp_src", 64'(rsp_src_o), 64'(mq[m_lock].src));
            check_eq("rsp_tag", 64'(rsp_tag_o), 64'(mq[m_lock].tag));
            check_eq("rsp_msg", rsp_msg_o, mq[m_lock].msg);
            check_eq("rsp_rd", 64'(rsp_rd_o), 64'(m_rd));
        end
        ins = in_valid_i && (mq.size() < SIZE);
        e.src = in_src_i;
        e.tag = in_tag_i;
        e.msg = in_msg_i;
        case (m_phase)
            0: if (req_valid_i && !flush) begin
                m_src = req_src_i; m_src_any = req_src_any_i;
                m_tag = req_tag_i; m_tag_any = req_tag_any_i;
                m_peek = req_peek_i; m_rd = req_rd_i;
                m_phase = 1;
            end
            1: if (flush) m_phase = 0;
               else begin
                   found = -1;
                   for (int i = 0; i < mq.size(); i++)
                       if (found < 0 && entry_match(mq[i])) found = i;
                   if (found >= 0) begin
                       m_lock = found;
                       m_phase = 2;
                   end
               end
            default: if (flush) m_phase = 0;
               else if (rsp_ready_i) begin
                   if (!m_peek) mq.delete(m_lock);
                   m_phase = 0;
               end
        endcase
        if (ins) mq.push_back(e);
        m_ins_fired = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] t, input logic [63:0] m);
        bit done = 1'b0;
        in_valid_i = 1'b1; in_src_i = s; in_tag_i = t; in_msg_i = m;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (m_ins_fired) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("push_timeout", 64'd0, 64'd1);
        in_valid_i = 1'b0;
    endtask

    task automatic issue(input logic [31:0] s, input bit sany, input logic [31:0] t,
                         input bit tany, input bit peek);
        req_valid_i = 1'b1; req_src_i = s; req_src_any_i = sany;
        req_tag_i = t; req_tag_any_i = tany; req_peek_i = peek;
        req_rd_i = 5'($urandom_range(0, 31));
        tick();
        req_valid_i = 1'b0;
    endtask

    // Wait for the response, check payload/latency, optionally complete it.
    task automatic wait_rsp(input logic [63:0] exp_msg, input int exp_lat, input bit take);
        int n = 0;
        while (m_phase != 2 && n < 50) begin
            tick();
            n++;
        end
        if (m_phase != 2) begin
            check_eq("rsp_timeout", 64'd0, 64'd1);
        end else begin
            check_eq("rsp_plan_msg", rsp_msg_o, exp_msg);
            if (exp_lat >= 0) check_eq("rsp_latency", 64'(n), 64'(exp_lat));
            if (take) begin
                rsp_ready_i = 1'b1;
                tick();
                rsp_ready_i = 1'b0;
            end
        end
    endtask

    task automatic request(input logic [31:0] s, input bit sany, input logic [31:0] t,
                           input bit tany, input bit peek, input logic [63:0] exp_msg);
        issue(s, sany, t, tany, peek);
        wait_rsp(exp_msg, 1, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        in_valid_i = 1'b0; in_src_i = '0; in_tag_i = '0; in_msg_i = '0;
        req_valid_i = 1'b0; req_src_i = '0; req_src_any_i = 1'b0;
        req_tag_i = '0; req_tag_any_i = 1'b0; req_peek_i = 1'b0; req_rd_i = 5'd0;
        rsp_ready_i = 1'b0;
        m_phase = 0; m_lock = 0; m_ins_fired = 1'b0;
        m_src = '0; m_tag = '0; m_src_any = 1'b0; m_tag_any = 1'b0; m_peek = 1'b0; m_rd = 5'd0;
        #22;
        check_eq("rst_occupancy", 64'(occupancy_o), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready_o), 64'd1);
        check_eq("rst_req_ready", 64'(req_ready_o), 64'd1);
        check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("rst_rsp_msg", rsp_msg_o, 64'd0);
        check_eq("rst_rsp_src", 64'(rsp_src_o), 64'd0);
        check_eq("rst_rsp_tag", 64'(rsp_tag_o), 64'd0);
        check_eq("rst_rsp_rd", 64'(rsp_rd_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic consume with minimum latency.
        push(32'd3, 32'd7, 64'hAA);
        check_eq("occ_one", 64'(occupancy_o), 64'd1);
        request(32'd3, 1'b0, 32'd7, 1'b0, 1'b0, 64'hAA);
        check_eq("occ_zero", 64'(occupancy_o), 64'd0);

        // Fill, stall a fifth message, consume the oldest.
        for (int i = 0; i < SIZE; i++) push(32'(i), 32'(100 + i), 64'(16'hF00 + i));
        check_eq("full_in_ready", 64'(in_ready_o), 64'd0);
        in_valid_i = 1'b1; in_src_i = 32'd9; in_tag_i = 32'd200; in_msg_i = 64'hF55;
        request(32'd0, 1'b1, 32'd100, 1'b0, 1'b0, 64'hF00);
        check_eq("in_ready_after_free", 64'(in_ready_o), 64'd1);
        tick();
        in_valid_i = 1'b0;
        check_eq("stalled_written", 64'(occupancy_o), 64'd4);
        request(32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 64'hF01);
        request(32'd0, 1'b1, 32'd102, 1'b0, 1'b0, 64'hF02);
        request(32'd9, 1'b0, 32'd0, 1'b1, 1'b0, 64'hF55);
        request(32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 64'hF03);

        // Oldest-match ordering.
        push(32'd1, 32'd1, 64'h10);
        push(32'd2, 32'd2, 64'h20);
        push(32'd3, 32'd1, 64'h30);
        request(32'd0, 1'b1, 32'd1, 1'b0, 1'b0, 64'h10);
        request(32'd0, 1'b1, 32'd1, 1'b0, 1'b0, 64'h30);
        request(32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 64'h20);

        // Peek keeps the entry; consume then removes it.
        push(32'd4, 32'd5, 64'h55);
        request(32'd0, 1'b1, 32'd5, 1'b0, 1'b1, 64'h55);
        check_eq("peek_occ", 64'(occupancy_o), 64'd1);
        request(32'd0, 1'b1, 32'd5, 1'b0, 1'b0, 64'h55);
        check_eq("consume_occ", 64'(occupancy_o), 64'd0);

        // Wait on an empty mailbox, satisfied by a later insert.
        issue(32'd0, 1'b1, 32'd9, 1'b0, 1'b0);
        repeat (5) tick();
        check_eq("empty_wait", 64'(rsp_valid_o), 64'd0);
        push(32'd8, 32'd9, 64'h99);
        wait_rsp(64'h99, 1, 1'b1);

        // Flush while holding a response.
        push(32'd6, 32'd6, 64'h66);
        issue(32'd0, 1'b1, 32'd6, 1'b0, 1'b0);
        wait_rsp(64'h66, 1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("flush_req_ready", 64'(req_ready_o), 64'd1);
        check_eq("flush_occ", 64'(occupancy_o), 64'd1);
        request(32'd0, 1'b1, 32'd6, 1'b0, 1'b0, 64'h66);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid_i    = ($urandom_range(0, 1) == 1);
            in_src_i      = 32'($urandom_range(0, 3));
            in_tag_i      = 32'($urandom_range(0, 3));
            in_msg_i      = {$urandom, $urandom};
            req_valid_i   = ($urandom_range(0, 9) < 3);
            req_src_i     = 32'($urandom_range(0, 3));
            req_src_any_i = ($urandom_range(0, 3) == 0);
            req_tag_i     = 32'($urandom_range(0, 3));
            req_tag_any_i = ($urandom_range(0, 3) == 0);
            req_peek_i    = ($urandom_range(0, 3) == 0);
            req_rd_i      = 5'($urandom_range(0, 31));
            rsp_ready_i   = ($urandom_range(0, 1) == 1);
            flush         = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
